// File: rtl/ext_bus_tx_fifo.sv
// External-bus slave that lets software queue 16-bit words into a TX FIFO and
// drains them to a valid/ready stream, with status/level/control registers and an IRQ.
module ext_bus_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [10:0] bus_address,
    input  logic        bus_bus_enable,
    input  logic [1:0]  bus_byte_enable,
    input  logic        bus_rw,
    input  logic [15:0] bus_write_data,
    output logic [15:0] bus_read_data,
    output logic        bus_acknowledge,
    output logic        bus_irq,
    output logic [15:0] st_data,
    output logic        st_valid,
    input  logic        st_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CMP_W = (LVL_W > 8) ? LVL_W : 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } bus_state_t;

    bus_state_t state, state_nxt;

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             ovf;
    logic             irq_en;
    logic [7:0]       thresh;

    logic [2:0]  reg_sel;
    logic        access, wr_en, push_req, push, pop, ovf_set, ovf_clr;
    logic        full, empty;
    logic [15:0] rd_mux;
    logic        unused_addr_bits;

    assign reg_sel          = bus_address[3:1];
    assign unused_addr_bits = ^{bus_address[10:4], bus_address[0]};

    // Side effects happen only on the IDLE-state edge, so a held enable acts once.
    assign access   = (state == S_IDLE) && bus_bus_enable;
    assign wr_en    = access && !bus_rw && (bus_byte_enable == 2'b11);
    assign push_req = wr_en && (reg_sel == 3'd0);
    assign ovf_clr  = wr_en && (reg_sel == 3'd1) && bus_write_data[2];

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push    = push_req && !full;
    assign ovf_set = push_req && full;
    assign pop     = !empty && st_ready;

    assign st_valid        = !empty;
    assign st_data         = mem[rd_ptr];
    assign bus_acknowledge = (state == S_ACK);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus_bus_enable) state_nxt = S_ACK;
            S_ACK:   state_nxt = bus_bus_enable ? S_WAIT : S_IDLE;
            S_WAIT:  if (!bus_bus_enable) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            3'd1:    rd_mux = {13'h0, ovf, full, empty};
            3'd2:    rd_mux = {thresh, 7'h0, irq_en};
            3'd3:    rd_mux = 16'(level);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            bus_read_data <= '0;
        end else if (access && bus_rw) begin
            bus_read_data <= rd_mux;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            irq_en <= 1'b0;
            thresh <= '0;
        end else if (wr_en && (reg_sel == 3'd2)) begin
            irq_en <= bus_write_data[0];
            thresh <= bus_write_data[15:8];
        end
    end

    // A fresh overflow beats a simultaneous software clear.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr] <= bus_write_data;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            bus_irq <= 1'b0;
        end else begin
            bus_irq <= irq_en && ((CMP_W'(level) <= CMP_W'(thresh)) || ovf);
        end
    end

endmodule

// File: tb/tb_ext_bus_tx_fifo.sv
// Directed and randomized bench for ext_bus_tx_fifo, checked against a queue-based
// model of the register map, FIFO and interrupt rules.
module tb_ext_bus_tx_fifo;

    localparam int DEPTH = 16;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [10:0] bus_address;
    logic        bus_bus_enable;
    logic [1:0]  bus_byte_enable;
    logic        bus_rw;
    logic [15:0] bus_write_data;
    logic [15:0] bus_read_data;
    logic        bus_acknowledge;
    logic        bus_irq;
    logic [15:0] st_data;
    logic        st_valid;
    logic        st_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_q [$];
    bit          m_ovf, m_irq_en, m_irq, m_ack;
    logic [7:0]  m_thresh;
    logic [15:0] m_rdata;

    bit          pend_valid;
    bit          pend_rw;
    logic [2:0]  pend_sel;
    logic [1:0]  pend_be;
    logic [15:0] pend_wd;

    ext_bus_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .bus_address     (bus_address),
        .bus_bus_enable  (bus_bus_enable),
        .bus_byte_enable (bus_byte_enable),
        .bus_rw          (bus_rw),
        .bus_write_data  (bus_write_data),
        .bus_read_data   (bus_read_data),
        .bus_acknowledge (bus_acknowledge),
        .bus_irq         (bus_irq),
        .st_data         (st_data),
        .st_valid        (st_valid),
        .st_ready        (st_ready)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] sel);
        int lvl;
        lvl = m_q.size();
        case (sel)
            3'd1:    return {13'h0, m_ovf, (lvl == DEPTH), (lvl == 0)};
            3'd2:    return {m_thresh, 7'h0, m_irq_en};
            3'd3:    return 16'(lvl);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_irq_en = 1'b0;
        m_irq    = 1'b0;
        m_ack    = 1'b0;
        m_thresh = 8'h00;
        m_rdata  = 16'h0000;
        pend_valid = 1'b0;
    endtask

    // Applies one clock edge of the reference rules using the inputs the bench is driving.
    task automatic model_update();
        int  old_lvl;
        bit  irq_n, do_push, ovf_set, ovf_clr;
        if (reset_reset) begin
            model_reset();
            return;
        end
        old_lvl = m_q.size();
        irq_n   = m_irq_en && ((old_lvl <= int'(m_thresh)) || m_ovf);
        m_ack   = pend_valid;
        do_push = 1'b0;
        ovf_set = 1'b0;
        ovf_clr = 1'b0;
        if (pend_valid) begin
            if (pend_rw) begin
                m_rdata = model_read(pend_sel);
            end else if (pend_be == 2'b11) begin
                case (pend_sel)
                    3'd0: if (old_lvl == DEPTH) ovf_set = 1'b1; else do_push = 1'b1;
                    3'd1: ovf_clr = pend_wd[2];
                    3'd2: begin
                        m_irq_en = pend_wd[0];
                        m_thresh = pend_wd[15:8];
                    end
                    default: ;
                endcase
            end
        end
        if (st_ready && old_lvl > 0) void'(m_q.pop_front());
        if (do_push) m_q.push_back(pend_wd);
        if (ovf_set) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_irq      = irq_n;
        pend_valid = 1'b0;
    endtask

    task automatic check_cycle();
        check_output("ack", 16'(bus_acknowledge), 16'(m_ack));
        check_output("st_valid", 16'(st_valid), 16'(m_q.size() != 0));
        if (m_q.size() != 0) check_output("st_data", st_data, m_q[0]);
        check_output("irq", 16'(bus_irq), 16'(m_irq));
        check_output("read_data", bus_read_data, m_rdata);
    endtask

    task automatic tick();
        @(posedge clk_clk);
        model_update();
        @(negedge clk_clk);
        check_cycle();
    endtask

    // One bus access with enable held for 'hold' cycles; must yield exactly one ack.
    task automatic apply_stimulus(input logic rw, input logic [10:0] addr, input logic [1:0] be,
                                  input logic [15:0] wd, input int hold, output logic [15:0] rdata);
        int acks;
        bus_bus_enable  = 1'b1;
        bus_rw          = rw;
        bus_address     = addr;
        bus_byte_enable = be;
        bus_write_data  = wd;
        pend_valid = 1'b1;
        pend_rw    = rw;
        pend_sel   = addr[3:1];
        pend_be    = be;
        pend_wd    = wd;
        acks  = 0;
        rdata = 16'hxxxx;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (i == 0) begin
                check_output("ack_latency", 16'(bus_acknowledge), 16'h0001);
                rdata = bus_read_data;
            end
            if (bus_acknowledge) acks++;
        end
        bus_bus_enable = 1'b0;
        tick();
        if (bus_acknowledge) acks++;
        check_output("ack_count", 16'(acks), 16'h0001);
    endtask

    task automatic bus_write(input logic [10:0] addr, input logic [15:0] wd);
        logic [15:0] dummy;
        apply_stimulus(1'b0, addr, 2'b11, wd, 1, dummy);
    endtask

    task automatic bus_read(input logic [10:0] addr, output logic [15:0] rdata);
        apply_stimulus(1'b1, addr, 2'b11, 16'h0000, 1, rdata);
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] word16;
        int          op;

        reset_reset     = 1'b1;
        bus_address     = '0;
        bus_bus_enable  = 1'b0;
        bus_byte_enable = 2'b00;
        bus_rw          = 1'b0;
        bus_write_data  = '0;
        st_ready        = 1'b0;
        model_reset();
        repeat (3) tick();
        reset_reset = 1'b0;
        tick();

        // Reset state and STATUS read
        check_output("reset_ack", 16'(bus_acknowledge), 16'h0000);
        check_output("reset_irq", 16'(bus_irq), 16'h0000);
        check_output("reset_valid", 16'(st_valid), 16'h0000);
        check_output("reset_rdata", bus_read_data, 16'h0000);
        bus_read(11'h002, rd);
        check_output("status_reset", rd, 16'h0001);

        // Three words, then stream them out on consecutive cycles
        bus_write(11'h000, 16'hA5A5);
        bus_write(11'h000, 16'h1234);
        bus_write(11'h000, 16'hBEEF);
        bus_read(11'h006, rd);
        check_output("level_3", rd, 16'h0003);
        st_ready = 1'b1;
        check_output("stream_0", st_data, 16'hA5A5);
        tick();
        check_output("stream_1", st_data, 16'h1234);
        tick();
        check_output("stream_2", st_data, 16'hBEEF);
        tick();
        check_output("stream_empty", 16'(st_valid), 16'h0000);
        st_ready = 1'b0;

        // Long-held enable and partial write
        apply_stimulus(1'b0, 11'h000, 2'b11, 16'h0042, 10, rd);
        bus_read(11'h006, rd);
        check_output("level_held", rd, 16'h0001);
        apply_stimulus(1'b0, 11'h000, 2'b01, 16'h0099, 1, rd);
        bus_read(11'h006, rd);
        check_output("level_partial", rd, 16'h0001);
        st_ready = 1'b1;
        tick();
        st_ready = 1'b0;

        // Overflow, W1C clear, and pop+push while full
        for (int i = 0; i < 17; i++) bus_write(11'h000, 16'h1000 + 16'(i));
        bus_read(11'h006, rd);
        check_output("level_full", rd, 16'h0010);
        bus_read(11'h002, rd);
        check_output("status_ovf", rd, 16'h0006);
        bus_write(11'h002, 16'h0004);
        bus_read(11'h002, rd);
        check_output("status_clr", rd, 16'h0002);
        st_ready = 1'b1;
        tick();
        st_ready = 1'b0;
        bus_write(11'h000, 16'h7777);
        st_ready = 1'b1;
        word16 = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            word16 = st_data;
            tick();
        end
        st_ready = 1'b0;
        check_output("sixteenth_word", word16, 16'h7777);
        check_output("drained", 16'(st_valid), 16'h0000);

        // Threshold interrupt
        bus_write(11'h004, 16'h0201);
        check_output("irq_empty", 16'(bus_irq), 16'h0001);
        bus_write(11'h000, 16'h0001);
        bus_write(11'h000, 16'h0002);
        bus_write(11'h000, 16'h0003);
        check_output("irq_level3", 16'(bus_irq), 16'h0000);
        st_ready = 1'b1;
        tick();
        st_ready = 1'b0;
        tick();
        check_output("irq_level2", 16'(bus_irq), 16'h0001);

        // Reset during the ACK cycle with words queued
        bus_write(11'h004, 16'h0305);
        bus_read(11'h004, rd);
        check_output("ctrl_readback", rd, 16'h0301);
        for (int i = 0; i < 3; i++) bus_write(11'h000, 16'h2000 + 16'(i));
        bus_bus_enable  = 1'b1;
        bus_rw          = 1'b0;
        bus_address     = 11'h000;
        bus_byte_enable = 2'b11;
        bus_write_data  = 16'h5555;
        pend_valid = 1'b1;
        pend_rw    = 1'b0;
        pend_sel   = 3'd0;
        pend_be    = 2'b11;
        pend_wd    = 16'h5555;
        tick();
        check_output("pre_reset_ack", 16'(bus_acknowledge), 16'h0001);
        reset_reset = 1'b1;
        #1;
        model_reset();
        check_output("rst_ack", 16'(bus_acknowledge), 16'h0000);
        check_output("rst_valid", 16'(st_valid), 16'h0000);
        bus_bus_enable = 1'b0;
        tick();
        reset_reset = 1'b0;
        tick();
        bus_read(11'h006, rd);
        check_output("rst_level", rd, 16'h0000);
        bus_read(11'h004, rd);
        check_output("rst_ctrl", rd, 16'h0000);
        bus_write(11'h000, 16'hCAFE);
        bus_read(11'h006, rd);
        check_output("post_rst_level", rd, 16'h0001);

        // Randomized traffic against the model
        for (int n = 0; n < 250; n++) begin
            st_ready = ($urandom_range(0, 9) < 3);
            op = $urandom_range(0, 19);
            if (op < 9)
                apply_stimulus(1'b0, 11'h000, 2'b11, 16'($urandom), $urandom_range(1, 3), rd);
            else if (op < 11)
                apply_stimulus(1'b0, 11'h000, 2'($urandom_range(0, 2)), 16'($urandom), 1, rd);
            else if (op < 14)
                apply_stimulus(1'b1, 11'($urandom_range(0, 15)), 2'b11, 16'h0000, $urandom_range(1, 2), rd);
            else if (op < 16)
                apply_stimulus(1'b0, 11'h004, 2'b11,
                               {8'($urandom_range(0, DEPTH + 2)), 7'h0, 1'($urandom)}, 1, rd);
            else if (op < 18)
                apply_stimulus(1'b0, 11'h002, 2'b11, 16'($urandom), 1, rd);
            else
                apply_stimulus(1'b0, 11'($urandom_range(8, 15)), 2'b11, 16'($urandom), 1, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
